fib_sequence_engine: RTL and testbench

Parametrised hardware sequence generator that fills an internal result buffer with an additive recurrence t[k] = t[k-1] + t[k-2] from two programmable seeds, e.g. Fibonacci (0,1) or Lucas (2,1). It replaces the bench-driven read/sum/write loop with a single start/done-handshaked engine. It adds configurable width and depth, a term count, wrap or saturate overflow handling, a sticky overflow flag, and a registered readback port usable while a run is in progress.

---
 rtl/fib_sequence_engine.sv | 210 +++++++++++++++++++++
 tb/tb_fib_sequence_engine.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fib_sequence_engine.sv
// fib_sequence_engine
// Fills an internal result buffer with the additive recurrence
// t[k] = t[k-1] + t[k-2], starting from two programmable seeds.
// A run starts with a start/done handshake. Each sum either wraps or
// saturates, and any carry sets a sticky overflow flag. A registered
// readback port gives access to the buffer, including while a run is
// in progress.

module fib_sequence_engine #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 16,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clockSignal,
    input  logic                  resetSignal,
    input  logic                  start,
    input  logic [ADDR_WIDTH:0]   termCount,
    input  logic [DATA_WIDTH-1:0] seed0,
    input  logic [DATA_WIDTH-1:0] seed1,
    input  logic                  saturateMode,
    output logic                  busy,
    output logic                  done,
    output logic                  overflow,
    output logic [ADDR_WIDTH:0]   termsWritten,
    input  logic                  readEnable,
    input  logic [ADDR_WIDTH-1:0] readAddress,
    output logic [DATA_WIDTH-1:0] dataRead,
    output logic                  readValid
);

    // Counts and indices carry one extra bit so that the value DEPTH itself
    // can be represented.
    localparam logic [ADDR_WIDTH:0] DEPTH_COUNT = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] ZERO_TERMS  = '0;
    localparam logic [ADDR_WIDTH:0] ONE_TERM    = (ADDR_WIDTH + 1)'(1);
    localparam logic [ADDR_WIDTH:0] TWO_TERMS   = (ADDR_WIDTH + 1)'(2);

    typedef enum logic [2:0] {
        IDLE,
        SEED0,
        SEED1,
        CALC,
        DONE
    } stateType;

    stateType              state;

    // Values captured when start is accepted. They stay frozen for the whole run.
    logic [ADDR_WIDTH:0]   countReg;
    logic [DATA_WIDTH-1:0] seed0Reg;
    logic [DATA_WIDTH-1:0] seed1Reg;
    logic                  satReg;

    // Recurrence state: termA is t[k-2] and termB is t[k-1]. writeIdx is the
    // buffer slot that receives t[k].
    logic [DATA_WIDTH-1:0] termA;
    logic [DATA_WIDTH-1:0] termB;
    logic [ADDR_WIDTH:0]   writeIdx;

    logic [DATA_WIDTH-1:0] bufMem [DEPTH];

    logic [DATA_WIDTH:0]   sumWide;
    logic [DATA_WIDTH-1:0] nextTerm;
    logic [ADDR_WIDTH:0]   lastIdx;
    logic [ADDR_WIDTH:0]   clampedCount;
    logic                  readInRange;

    // Requested term counts above the buffer size are limited to the buffer size.
    function automatic logic [ADDR_WIDTH:0] clampCount(input logic [ADDR_WIDTH:0] requested);
        if (requested > DEPTH_COUNT) begin
            return DEPTH_COUNT;
        end
        return requested;
    endfunction

    // Turns a carry-extended sum into a stored term. With saturation, the
    // result is pinned at all-ones. Otherwise the carry is discarded
    // (modulo 2^DATA_WIDTH).
    function automatic logic [DATA_WIDTH-1:0] limitTerm(input logic [DATA_WIDTH:0] sum,
                                                        input logic                saturate);
        if (sum[DATA_WIDTH] && saturate) begin
            return '1;
        end
        return sum[DATA_WIDTH-1:0];
    endfunction

    // Sum of the two previous terms, the limited next term and the index of the final term.
    always_comb begin
        sumWide      = {1'b0, termA} + {1'b0, termB};
        nextTerm     = limitTerm(sumWide, satReg);
        lastIdx      = countReg - ONE_TERM;
        clampedCount = clampCount(termCount);
        readInRange  = ({1'b0, readAddress} < DEPTH_COUNT);
    end

    // Run sequencer: captures the inputs, writes the seeds and then one computed
    // term per cycle, and drives the registered handshake and status outputs.
    always_ff @(posedge clockSignal) begin
        if (resetSignal) begin
            state        <= IDLE;
            busy         <= 1'b0;
            done         <= 1'b0;
            overflow     <= 1'b0;
            termsWritten <= '0;
            countReg     <= '0;
            seed0Reg     <= '0;
            seed1Reg     <= '0;
            satReg       <= 1'b0;
            termA        <= '0;
            termB        <= '0;
            writeIdx     <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                bufMem[i] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        countReg     <= clampedCount;
                        seed0Reg     <= seed0;
                        seed1Reg     <= seed1;
                        satReg       <= saturateMode;
                        termsWritten <= '0;
                        overflow     <= 1'b0;
                        if (clampedCount == ZERO_TERMS) begin
                            // Nothing to write: go straight to the done pulse.
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= SEED0;
                            busy  <= 1'b1;
                        end
                    end
                end

                SEED0: begin
                    bufMem[0]    <= seed0Reg;
                    termsWritten <= ONE_TERM;
                    if (countReg == ONE_TERM) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        state <= SEED1;
                    end
                end

                SEED1: begin
                    bufMem[1]    <= seed1Reg;
                    termsWritten <= TWO_TERMS;
                    termA        <= seed0Reg;
                    termB        <= seed1Reg;
                    writeIdx     <= TWO_TERMS;
                    if (countReg == TWO_TERMS) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        state <= CALC;
                    end
                end

                CALC: begin
                    bufMem[writeIdx[ADDR_WIDTH-1:0]] <= nextTerm;
                    // Sticky flag: it only ever sets during a run. Once the
                    // terms saturate, every later sum carries as well.
                    if (sumWide[DATA_WIDTH]) begin
                        overflow <= 1'b1;
                    end
                    termA        <= termB;
                    termB        <= nextTerm;
                    writeIdx     <= writeIdx + 1'b1;
                    termsWritten <= termsWritten + 1'b1;
                    if (writeIdx == lastIdx) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end

                DONE: begin
                    state <= IDLE;
                    done  <= 1'b0;
                end

                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

    // Registered readback: one cycle of latency. The output holds its value
    // between requests. A read of the slot being written on the same edge
    // returns the old contents.
    always_ff @(posedge clockSignal) begin
        if (resetSignal) begin
            dataRead  <= '0;
            readValid <= 1'b0;
        end else begin
            readValid <= readEnable;
            if (readEnable) begin
                dataRead <= readInRange ? bufMem[readAddress] : '0;
            end
        end
    end

endmodule

// File: tb/tb_fib_sequence_engine.sv
// Testbench for fib_sequence_engine. Two instances, one 32 bits wide and
// one 8 bits wide, share the same stimulus. Readback expectations pass
// through a scoreboard queue.
`timescale 1ns/1ps

module tb_fib_sequence_engine;

    localparam int DEPTH      = 16;
    localparam int ADDR_WIDTH = 4;

    logic clk = 1'b0;
    logic resetSignal, start, saturateMode, readEnable;
    logic [ADDR_WIDTH:0]   termCount;
    logic [31:0]           seed0, seed1;
    logic [ADDR_WIDTH-1:0] readAddress;

    logic busy32, done32, overflow32, readValid32;
    logic [ADDR_WIDTH:0] termsWritten32;
    logic [31:0] dataRead32;
    logic busy8, done8, overflow8, readValid8;
    logic [ADDR_WIDTH:0] termsWritten8;
    logic [7:0] dataRead8;

    fib_sequence_engine #(.DATA_WIDTH(32), .DEPTH(DEPTH), .ADDR_WIDTH(ADDR_WIDTH)) dut32 (
        .clockSignal(clk), .resetSignal(resetSignal), .start(start), .termCount(termCount),
        .seed0(seed0), .seed1(seed1), .saturateMode(saturateMode),
        .busy(busy32), .done(done32), .overflow(overflow32), .termsWritten(termsWritten32),
        .readEnable(readEnable), .readAddress(readAddress), .dataRead(dataRead32),
        .readValid(readValid32));

    fib_sequence_engine #(.DATA_WIDTH(8), .DEPTH(DEPTH), .ADDR_WIDTH(ADDR_WIDTH)) dut8 (
        .clockSignal(clk), .resetSignal(resetSignal), .start(start), .termCount(termCount),
        .seed0(seed0[7:0]), .seed1(seed1[7:0]), .saturateMode(saturateMode),
        .busy(busy8), .done(done8), .overflow(overflow8), .termsWritten(termsWritten8),
        .readEnable(readEnable), .readAddress(readAddress), .dataRead(dataRead8),
        .readValid(readValid8));

    always #5 clk = ~clk;

    typedef struct {
        int          n;
        logic [31:0] s0;
        logic [31:0] s1;
        logic        sat;
        int          expWritten;
        int          ovfCyc32;   // cycle after start in which overflow first reads 1, 0 = never
        int          ovfCyc8;
        int          midAddr;    // address read twice while busy, -1 = none
        logic        glitch;     // pulse start while busy
        int          spotAddr;
        logic [31:0] spot32;
        logic [7:0]  spot8;
    } vec_t;

    typedef struct {
        int          addr;
        logic [31:0] e32;
        logic [7:0]  e8;
    } rd_t;

    vec_t        tbl [8];
    rd_t         sb [$];
    logic [31:0] model32 [DEPTH];
    logic [7:0]  model8 [DEPTH];
    logic [31:0] lastE32;
    logic [7:0]  lastE8;
    int          vectors = 0;
    int          miscompares = 0;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    function automatic longint addTerms(input longint a, input longint b, input longint maxVal,
                                        input logic sat);
        longint s;
        s = a + b;
        if (s > maxVal) begin
            return sat ? maxVal : (s - maxVal - 1);
        end
        return s;
    endfunction

    task automatic buildModel(input int n, input logic [31:0] s0, input logic [31:0] s1,
                              input logic sat);
        longint a32, b32, a8, b8, t32, t8;
        int cnt;
        cnt = (n > DEPTH) ? DEPTH : n;
        a32 = 0; b32 = 0; a8 = 0; b8 = 0;
        for (int k = 0; k < cnt; k++) begin
            if (k == 0) begin
                t32 = longint'(s0); t8 = longint'(s0[7:0]);
            end else if (k == 1) begin
                t32 = longint'(s1); t8 = longint'(s1[7:0]);
            end else begin
                t32 = addTerms(a32, b32, 64'hFFFF_FFFF, sat);
                t8  = addTerms(a8, b8, 64'hFF, sat);
            end
            a32 = b32; b32 = t32; a8 = b8; b8 = t8;
            model32[k] = 32'(t32);
            model8[k]  = 8'(t8);
        end
    endtask

    task automatic issueRead(input int addr, input logic [31:0] e32, input logic [7:0] e8);
        rd_t r;
        r.addr = addr; r.e32 = e32; r.e8 = e8;
        readEnable  = 1'b1;
        readAddress = 4'(addr);
        lastE32 = e32; lastE8 = e8;
        sb.push_back(r);
    endtask

    task automatic serviceRead();
        rd_t r;
        if (sb.size() > 0) begin
            r = sb.pop_front();
            check("readValid32", 32'(readValid32), 32'd1);
            check("readValid8", 32'(readValid8), 32'd1);
            check($sformatf("dataRead32[%0d]", r.addr), dataRead32, r.e32);
            check($sformatf("dataRead8[%0d]", r.addr), 32'(dataRead8), 32'(r.e8));
        end
    endtask

    task automatic readAll(input int spotAddr, input logic [31:0] s32, input logic [7:0] s8);
        for (int i = 0; i <= DEPTH; i++) begin
            @(negedge clk);
            serviceRead();
            if (i < DEPTH) issueRead(i, model32[i], model8[i]);
            else if (spotAddr >= 0) issueRead(spotAddr, s32, s8);
            else readEnable = 1'b0;
        end
        @(negedge clk);
        serviceRead();
        readEnable = 1'b0;
        @(negedge clk);
        check("readValidIdle32", 32'(readValid32), 32'd0);
        check("dataReadHold32", dataRead32, lastE32);
        check("dataReadHold8", 32'(dataRead8), 32'(lastE8));
    endtask

    task automatic runVector(input vec_t v);
        int doneC32, doneC8, busyN32, busyN8, ovfC32, ovfC8, cnt;
        logic [31:0] old32 [DEPTH];
        logic [7:0]  old8 [DEPTH];
        old32 = model32;
        old8  = model8;
        buildModel(v.n, v.s0, v.s1, v.sat);
        cnt = (v.n > DEPTH) ? DEPTH : v.n;
        doneC32 = 0; doneC8 = 0; busyN32 = 0; busyN8 = 0; ovfC32 = 0; ovfC8 = 0;
        @(negedge clk);
        termCount = 5'(v.n); seed0 = v.s0; seed1 = v.s1; saturateMode = v.sat;
        start = 1'b1; readEnable = 1'b0;
        @(posedge clk);
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            serviceRead();
            if (doneC32 == 0) begin
                if (overflow32 && ovfC32 == 0) ovfC32 = c;
                if (done32) begin
                    doneC32 = c;
                    check("busyAtDone32", 32'(busy32), 32'd0);
                    check("termsWritten32", 32'(termsWritten32), v.expWritten);
                    check("overflow32", 32'(overflow32), 32'(v.ovfCyc32 != 0));
                end else if (busy32) busyN32++;
            end
            if (doneC8 == 0) begin
                if (overflow8 && ovfC8 == 0) ovfC8 = c;
                if (done8) begin
                    doneC8 = c;
                    check("busyAtDone8", 32'(busy8), 32'd0);
                    check("termsWritten8", 32'(termsWritten8), v.expWritten);
                    check("overflow8", 32'(overflow8), 32'(v.ovfCyc8 != 0));
                end else if (busy8) busyN8++;
            end
            start = v.glitch && (c == 3);
            if (c == 1) begin
                // Scramble the inputs: the run must use only the captured values.
                seed0 = $urandom; seed1 = $urandom; saturateMode = ~v.sat;
                termCount = 5'($urandom_range(0, 31));
            end
            if (v.midAddr >= 0 && (c == v.midAddr + 1 || c == v.midAddr + 2)) begin
                if (v.midAddr < cnt && c > v.midAddr + 1)
                    issueRead(v.midAddr, model32[v.midAddr], model8[v.midAddr]);
                else
                    issueRead(v.midAddr, old32[v.midAddr], old8[v.midAddr]);
            end else begin
                readEnable = 1'b0;
            end
            if (doneC32 != 0 && doneC8 != 0 && sb.size() == 0) break;
        end
        start = 1'b0;
        check("doneCycle32", doneC32, v.expWritten + 1);
        check("doneCycle8", doneC8, v.expWritten + 1);
        check("busyCycles32", busyN32, v.expWritten);
        check("busyCycles8", busyN8, v.expWritten);
        check("overflowRise32", ovfC32, v.ovfCyc32);
        check("overflowRise8", ovfC8, v.ovfCyc8);
        @(negedge clk);
        check("donePulse32", 32'(done32), 32'd0);
        check("donePulse8", 32'(done8), 32'd0);
        readAll(v.spotAddr, v.spot32, v.spot8);
    endtask

    task automatic checkAllZero(input string tag);
        check({tag, "_busy32"}, 32'(busy32), 32'd0);
        check({tag, "_done32"}, 32'(done32), 32'd0);
        check({tag, "_overflow32"}, 32'(overflow32), 32'd0);
        check({tag, "_termsWritten32"}, 32'(termsWritten32), 32'd0);
        check({tag, "_readValid32"}, 32'(readValid32), 32'd0);
        check({tag, "_dataRead32"}, dataRead32, 32'd0);
        check({tag, "_busy8"}, 32'(busy8), 32'd0);
        check({tag, "_done8"}, 32'(done8), 32'd0);
        check({tag, "_overflow8"}, 32'(overflow8), 32'd0);
        check({tag, "_termsWritten8"}, 32'(termsWritten8), 32'd0);
        check({tag, "_readValid8"}, 32'(readValid8), 32'd0);
        check({tag, "_dataRead8"}, 32'(dataRead8), 32'd0);
    endtask

    task automatic resetMidRun();
        int sawDone;
        sawDone = 0;
        @(negedge clk);
        termCount = 5'd12; seed0 = 32'd0; seed1 = 32'd1; saturateMode = 1'b0; start = 1'b1;
        @(posedge clk);
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (done32 || done8) sawDone = 1;
            if (c == 5) begin
                check("busyBeforeReset32", 32'(busy32), 32'd1);
                resetSignal = 1'b1;
            end
        end
        @(negedge clk);
        resetSignal = 1'b0;
        checkAllZero("afterReset");
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (done32 || done8) sawDone = 1;
        end
        check("noDoneAfterReset", sawDone, 0);
        for (int k = 0; k < DEPTH; k++) begin
            model32[k] = '0; model8[k] = '0;
        end
        readAll(-1, 32'd0, 8'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        resetSignal = 1'b1; start = 1'b0; termCount = '0; seed0 = '0; seed1 = '0;
        saturateMode = 1'b0; readEnable = 1'b0; readAddress = '0;
        lastE32 = '0; lastE8 = '0;
        for (int k = 0; k < DEPTH; k++) begin
            model32[k] = '0; model8[k] = '0;
        end
        //         n   s0             s1          sat  wr ov32 ov8 mid glitch spot  spot32         spot8
        tbl[0] = '{12, 32'd0,         32'd1,      1'b0, 12, 0,  0,  -1, 1'b0, 11, 32'd89,        8'd89};
        tbl[1] = '{8,  32'd2,         32'd1,      1'b0, 8,  0,  0,   3, 1'b0,  3, 32'd4,         8'd4};
        tbl[2] = '{16, 32'd0,         32'd1,      1'b0, 16, 0,  16, -1, 1'b1, 14, 32'd377,       8'd121};
        tbl[3] = '{16, 32'd0,         32'd1,      1'b1, 16, 0,  16, -1, 1'b0, 15, 32'd610,       8'd255};
        tbl[4] = '{0,  32'd7,         32'd9,      1'b0, 0,  0,  0,  -1, 1'b0,  0, 32'd0,         8'd0};
        tbl[5] = '{1,  32'd7,         32'd9,      1'b0, 1,  0,  0,  -1, 1'b0,  1, 32'd1,         8'd1};
        tbl[6] = '{20, 32'd3,         32'd4,      1'b0, 16, 0,  12, -1, 1'b0, 15, 32'd3571,      8'd243};
        tbl[7] = '{4,  32'hFFFF_FFF0, 32'h20,     1'b1, 4,  4,  4,  -1, 1'b1,  3, 32'hFFFF_FFFF, 8'hFF};

        repeat (3) @(posedge clk);
        @(negedge clk);
        resetSignal = 1'b0;
        checkAllZero("reset");
        readAll(-1, 32'd0, 8'd0);

        for (int i = 0; i < 8; i++) runVector(tbl[i]);
        resetMidRun();
        runVector(tbl[0]);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
